// File: rtl/seq_deser_8b_bidir_pkg.sv
// Shared constants and the bit-insertion helper for the 8-bit bidirectional deserializer.
package seq_deser_8b_bidir_pkg;

  localparam int unsigned NBITS = 8;
  localparam int unsigned CNTW  = 3;

  localparam logic OP_MSB_FIRST = 1'b0;
  localparam logic OP_LSB_FIRST = 1'b1;

  // Shift one serial bit into the accumulator in the requested order.
  function automatic logic [NBITS-1:0] shift_in(input logic [NBITS-1:0] acc,
                                                input logic             sin,
                                                input logic             order);
    if (order == OP_LSB_FIRST) return {sin, acc[NBITS-1:1]};
    else                       return {acc[NBITS-2:0], sin};
  endfunction

endpackage

// File: rtl/seq_deser_outreg.sv
// One-entry val/rdy pipeline register holding the delivered word.
//   clk, reset  : clock, synchronous active-high reset
//   din/din_val : word offered for loading; din_rdy_c says the slot is free or draining
//   dout/dout_val/dout_rdy : consumer-side handshake; dout holds while dout_val is 0
module seq_deser_outreg
  import seq_deser_8b_bidir_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] din,
  input  logic             din_val,
  output logic             din_rdy_c,
  output logic [NBITS-1:0] dout,
  output logic             dout_val,
  input  logic             dout_rdy
);

  // Slot can take a word if empty or being drained this cycle.
  assign din_rdy_c = !dout_val || dout_rdy;

  // Load has priority over drain so back-to-back words keep dout_val high.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= '0;
      dout_val <= 1'b0;
    end else if (din_val && din_rdy_c) begin
      dout     <= din;
      dout_val <= 1'b1;
    end else if (dout_rdy) begin
      dout_val <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_deser_8b_bidir.sv
// Serial-to-parallel 8-bit deserializer with per-word selectable bit order.
//   clk, reset : clock, synchronous active-high reset
//   en, sin    : serial bit and its valid; accepted when en && in_rdy
//   op         : order for the word being started (0 MSB-first, 1 LSB-first)
//   clr        : drop the partial word and any word waiting for the output slot
//   in_rdy     : accumulator can accept a bit
//   pout, pout_val, pout_rdy : deserialized word handshake
module seq_deser_8b_bidir
  import seq_deser_8b_bidir_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sin,
  input  logic             op,
  input  logic             clr,
  output logic             in_rdy,
  output logic [NBITS-1:0] pout,
  output logic             pout_val,
  input  logic             pout_rdy
);

  logic [NBITS-1:0] acc_q;
  logic [CNTW-1:0]  cnt_q;
  logic             acc_full_q;
  logic             ord_q;

  logic             accept_c;
  logic             ord_c;
  logic             last_c;
  logic [NBITS-1:0] word_c;
  logic             load_val_c;
  logic [NBITS-1:0] load_data_c;
  logic             out_rdy_c;

  assign in_rdy = !acc_full_q;

  // Bit acceptance and the word offered to the output register.
  always_comb begin
    accept_c    = en && !acc_full_q && !clr;
    ord_c       = (cnt_q == '0) ? op : ord_q;
    word_c      = shift_in(acc_q, sin, ord_c);
    last_c      = accept_c && (cnt_q == CNTW'(NBITS - 1));
    // A pending full word goes first; while full no bit is accepted, so the two never collide.
    load_val_c  = (acc_full_q && !clr) || last_c;
    load_data_c = acc_full_q ? acc_q : word_c;
  end

  // Accumulator, bit counter, latched order and pending-word flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_full_q <= 1'b0;
      ord_q      <= OP_MSB_FIRST;
    end else if (clr) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_full_q <= 1'b0;
    end else begin
      if (accept_c) begin
        acc_q <= word_c;
        cnt_q <= cnt_q + CNTW'(1);
        if (cnt_q == '0) ord_q <= op;
        if (last_c && !out_rdy_c) acc_full_q <= 1'b1;
      end
      if (acc_full_q && out_rdy_c) acc_full_q <= 1'b0;
    end
  end

  seq_deser_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .din       (load_data_c),
    .din_val   (load_val_c),
    .din_rdy_c (out_rdy_c),
    .dout      (pout),
    .dout_val  (pout_val),
    .dout_rdy  (pout_rdy)
  );

endmodule

// File: tb/tb_seq_deser_8b_bidir.sv
// Directed bench for seq_deser_8b_bidir with a word scoreboard.
module tb_seq_deser_8b_bidir;

  logic       clk = 1'b0;
  logic       reset, en, sin, op, clr, pout_rdy;
  logic       in_rdy, pout_val;
  logic [7:0] pout;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  seq_deser_8b_bidir dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sin      (sin),
    .op       (op),
    .clr      (clr),
    .in_rdy   (in_rdy),
    .pout     (pout),
    .pout_val (pout_val),
    .pout_rdy (pout_rdy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Score any transfer that the coming edge will perform, then advance one cycle.
  task automatic tick();
    logic [7:0] e;
    if (!reset && pout_val === 1'b1 && pout_rdy) begin
      check("sb_nonempty", 8'(sb.size() != 0), 8'h01);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("word", pout, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e_, input logic s_, input logic o_,
                       input logic c_, input logic r_);
    en = e_; sin = s_; op = o_; clr = c_; pout_rdy = r_;
    tick();
  endtask

  // Sends seq[7] first down to seq[0].
  task automatic send_seq(input logic [7:0] seq, input logic o, input logic r);
    for (int i = 7; i >= 0; i--) drive(1'b1, seq[i], o, 1'b0, r);
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  initial begin
    logic [7:0] latch_seq;
    latch_seq = 8'b1111_0000;
    reset = 1'b1; en = 1'b0; sin = 1'b0; op = 1'b0; clr = 1'b0; pout_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_pout", pout, 8'h00);
    check("rst_val", {7'd0, pout_val}, 8'h00);
    check("rst_in_rdy", {7'd0, in_rdy}, 8'h01);
    reset = 1'b0;
    idle(1'b1, 1);

    // MSB-first, one-cycle valid, value held afterwards
    sb.push_back(8'hB2);
    send_seq(8'b1011_0010, 1'b0, 1'b1);
    check("msb_val", {7'd0, pout_val}, 8'h01);
    check("msb_pout", pout, 8'hB2);
    idle(1'b1, 1);
    check("msb_val_drop", {7'd0, pout_val}, 8'h00);
    check("msb_hold", pout, 8'hB2);

    // LSB-first, same bits
    sb.push_back(8'h4D);
    send_seq(8'b1011_0010, 1'b1, 1'b1);
    check("lsb_pout", pout, 8'h4D);
    idle(1'b1, 1);

    // Order latched on first bit; op toggles afterwards
    sb.push_back(8'hF0);
    for (int i = 0; i < 8; i++) drive(1'b1, latch_seq[7-i], 1'(i % 2), 1'b0, 1'b1);
    check("latch_pout", pout, 8'hF0);
    idle(1'b1, 1);

    // Backpressure: second word waits in the accumulator
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    send_seq(8'hA5, 1'b0, 1'b0);
    check("bp_val1", {7'd0, pout_val}, 8'h01);
    check("bp_in_rdy1", {7'd0, in_rdy}, 8'h01);
    send_seq(8'h3C, 1'b0, 1'b0);
    check("bp_in_rdy_full", {7'd0, in_rdy}, 8'h00);
    check("bp_hold", pout, 8'hA5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_ignored", {7'd0, in_rdy}, 8'h00);
    idle(1'b1, 1);
    check("bp_second", pout, 8'h3C);
    check("bp_second_val", {7'd0, pout_val}, 8'h01);
    check("bp_in_rdy_back", {7'd0, in_rdy}, 8'h01);
    idle(1'b1, 1);
    check("bp_empty", {7'd0, pout_val}, 8'h00);

    // Throughput: back-to-back words with pout_rdy high
    sb.push_back(8'h69);
    sb.push_back(8'h96);
    send_seq(8'h69, 1'b0, 1'b1);
    check("tp_first", pout, 8'h69);
    send_seq(8'h96, 1'b0, 1'b1);
    check("tp_second", pout, 8'h96);
    check("tp_in_rdy", {7'd0, in_rdy}, 8'h01);
    idle(1'b1, 1);

    // clr mid-word wins over en and leaves the output register alone
    sb.push_back(8'hC3);
    send_seq(8'hC3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_val_kept", {7'd0, pout_val}, 8'h01);
    check("clr_pout_kept", pout, 8'hC3);
    sb.push_back(8'h81);
    send_seq(8'h81, 1'b0, 1'b1);
    check("clr_pout", pout, 8'h81);
    idle(1'b1, 1);

    // 8th bit completes in the same cycle a held word drains
    sb.push_back(8'hE7);
    sb.push_back(8'h18);
    send_seq(8'hE7, 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) drive(1'b1, 1'(8'h18 >> i), 1'b0, 1'b0, 1'b0);
    check("sim_val_before", {7'd0, pout_val}, 8'h01);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sim_val_cont", {7'd0, pout_val}, 8'h01);
    check("sim_pout", pout, 8'h18);
    idle(1'b1, 1);

    // Reset mid-word with a held word: everything discarded
    sb.push_back(8'h5A);
    send_seq(8'h5A, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst2_val", {7'd0, pout_val}, 8'h00);
    check("rst2_pout", pout, 8'h00);
    check("rst2_in_rdy", {7'd0, in_rdy}, 8'h01);
    sb.delete();
    reset = 1'b0;
    sb.push_back(8'h81);
    send_seq(8'h81, 1'b0, 1'b1);
    check("rst2_pout_after", pout, 8'h81);
    idle(1'b1, 2);

    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
